// File: rtl/upsched_pkg.sv
// upsample_scheduler shared types: FSM states, default widths, rate clamp.
package upsched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    STOP
  } state_t;

  localparam int DATA_W_DEF = 4;
  localparam int RATE_W_DEF = 4;

  function automatic logic [31:0] clamp_rate(input logic [31:0] r);
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/upsched_fifo.sv
// Symbol buffer for the scheduler: synchronous FIFO, pointers with wrap bit.
module upsched_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty
);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign level = wr_q - rd_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/upsample_scheduler.sv
// Releases one buffered symbol per upsampling period and owns the phase counter.
// Optional UPSCHED_UFLOW_CNT_EN adds a saturating underflow counter output.
module upsample_scheduler
  import upsched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RATE_W     = RATE_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int PRIME_LVL  = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_cfg,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] sym_data,
  output logic              sym_strobe,
  output logic [RATE_W-1:0] phase,
  output logic              active,
  output logic              underflow,
`ifdef UPSCHED_UFLOW_CNT_EN
  output logic [15:0]       uflow_cnt,
`endif
  output logic [LW-1:0]     fifo_level
);

  state_t            state_q, state_d;
  logic [RATE_W-1:0] phase_q, phase_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [DATA_W-1:0] sym_q, sym_d;
  logic              strobe_q, strobe_d;
  logic              uflow_q, uflow_d;

  logic              push, pop, start, last;
  logic              full, empty;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level;
  logic [RATE_W-1:0] rate_eff;

  upsched_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (s_data),
    .dout (head),
    .level(level),
    .full (full),
    .empty(empty)
  );

  assign rate_eff = RATE_W'(clamp_rate(32'(rate_cfg)));
  assign last     = (phase_q == rate_q - RATE_W'(1));
  assign push     = s_valid && !full;
  assign pop      = start && !empty;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rate_d   = rate_q;
    sym_d    = sym_q;
    strobe_d = 1'b0;
    uflow_d  = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rate_d  = rate_eff;
        phase_d = '0;
        sym_d   = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        rate_d = rate_eff;
        if (!enable) begin
          state_d = IDLE;
        end else if (level >= LW'(PRIME_LVL)) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN, STOP: begin
        // Periods are never cut short: only the last sample decides.
        if (enable)    state_d = RUN;
        else if (last) state_d = IDLE;
        else           state_d = STOP;
        if (last) rate_d = rate_eff;
        if (last && enable) begin
          start = 1'b1;
        end else if (last) begin
          phase_d = '0;
          sym_d   = '0;
        end else begin
          phase_d = phase_q + RATE_W'(1);
        end
      end
    endcase
    if (start) begin
      phase_d  = '0;
      strobe_d = 1'b1;
      if (empty) begin
        sym_d   = '0;
        uflow_d = 1'b1;
      end else begin
        sym_d = head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      rate_q   <= RATE_W'(1);
      sym_q    <= '0;
      strobe_q <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rate_q   <= rate_d;
      sym_q    <= sym_d;
      strobe_q <= strobe_d;
      uflow_q  <= uflow_d;
    end
  end

`ifdef UPSCHED_UFLOW_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && enable) cnt_d = '0;
    else if (uflow_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign uflow_cnt = cnt_q;
`endif

  assign s_ready    = !full;
  assign sym_data   = sym_q;
  assign sym_strobe = strobe_q;
  assign phase      = phase_q;
  assign active     = (state_q == RUN) || (state_q == STOP);
  assign underflow  = uflow_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_upsample_scheduler.sv
// Directed bench for upsample_scheduler: vector table plus hand sequences.
module tb_upsample_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] rate_cfg = 4'd0;
  logic [3:0] s_data = 4'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] sym_data;
  logic       sym_strobe;
  logic [3:0] phase;
  logic       active;
  logic       underflow;
  logic [3:0] fifo_level;
`ifdef UPSCHED_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  upsample_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rate_cfg  (rate_cfg),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .sym_data  (sym_data),
    .sym_strobe(sym_strobe),
    .phase     (phase),
    .active    (active),
    .underflow (underflow),
`ifdef UPSCHED_UFLOW_CNT_EN
    .uflow_cnt (uflow_cnt),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] rate;
    logic       sv;
    logic [3:0] sd;
    logic       st;
    logic [3:0] ph;
    logic [3:0] sym;
    logic       act;
    logic       uf;
    logic [3:0] lvl;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    enable   = 1'b0;
    rate_cfg = 4'd0;
    s_valid  = 1'b0;
    s_data   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(i + 1);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] r);
    rate_cfg = r;
    enable   = 1'b1;
    step();
    step();
  endtask

  task automatic chk_out(input string tag, input int st, input int ph,
                         input int sym);
    chk({tag, " strobe"}, int'(sym_strobe), st);
    chk({tag, " phase"}, int'(phase), ph);
    chk({tag, " sym"}, int'(sym_data), sym);
  endtask

  initial begin
    tbl[0] = '{1, 4, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 4, 1, 2, 0, 0, 0, 0, 0, 1};
    tbl[2] = '{1, 4, 1, 3, 0, 0, 0, 0, 0, 2};
    tbl[3] = '{1, 4, 1, 4, 0, 0, 0, 0, 0, 3};
    tbl[4] = '{1, 4, 1, 5, 0, 0, 0, 0, 0, 4};
    tbl[5] = '{1, 4, 1, 6, 1, 0, 1, 1, 0, 4};
    tbl[6] = '{1, 4, 1, 7, 0, 1, 1, 1, 0, 5};
    tbl[7] = '{1, 4, 1, 8, 0, 2, 1, 1, 0, 6};
    tbl[8] = '{1, 4, 0, 0, 0, 3, 1, 1, 0, 7};

    // Stream 1..8 at rate 4
    do_reset();
    @(negedge clk);
    chk("reset s_ready", int'(s_ready), 1);
    for (int i = 0; i < 9; i++) begin
      enable   = tbl[i].en;
      rate_cfg = tbl[i].rate;
      s_valid  = tbl[i].sv;
      s_data   = tbl[i].sd;
      chk($sformatf("v%0d strobe", i), int'(sym_strobe), int'(tbl[i].st));
      chk($sformatf("v%0d phase", i), int'(phase), int'(tbl[i].ph));
      chk($sformatf("v%0d sym", i), int'(sym_data), int'(tbl[i].sym));
      chk($sformatf("v%0d active", i), int'(active), int'(tbl[i].act));
      chk($sformatf("v%0d uflow", i), int'(underflow), int'(tbl[i].uf));
      chk($sformatf("v%0d level", i), int'(fifo_level), int'(tbl[i].lvl));
      step();
    end
    for (int k = 2; k <= 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        chk_out($sformatf("s%0d.%0d", k, p), (p == 0) ? 1 : 0, p, k);
        chk($sformatf("s%0d.%0d level", k, p), int'(fifo_level), 8 - k);
        step();
      end
    end
    chk_out("drain", 1, 0, 0);
    chk("drain uflow", int'(underflow), 1);
    step();
    chk("drain uflow end", int'(underflow), 0);

    // Full FIFO back-pressure
    do_reset();
    preload(8);
    s_valid = 1'b1;
    s_data  = 4'd9;
    chk("full level", int'(fifo_level), 8);
    chk("full s_ready", int'(s_ready), 0);
    step();
    chk("full hold", int'(fifo_level), 8);
    start_run(4'd4);
    chk("full pop level", int'(fifo_level), 7);
    chk("full pop ready", int'(s_ready), 1);
    chk("full pop sym", int'(sym_data), 1);
    step();
    chk("refill level", int'(fifo_level), 8);
    chk("refill ready", int'(s_ready), 0);
    s_valid = 1'b0;

    // Rate change mid-period, then rate 0
    do_reset();
    preload(8);
    start_run(4'd4);
    chk_out("rc0", 1, 0, 1);
    step();
    chk_out("rc1", 0, 1, 1);
    rate_cfg = 4'd2;
    step();
    chk_out("rc2", 0, 2, 1);
    step();
    chk_out("rc3", 0, 3, 1);
    step();
    chk_out("rc4", 1, 0, 2);
    step();
    chk_out("rc5", 0, 1, 2);
    step();
    chk_out("rc6", 1, 0, 3);
    rate_cfg = 4'd0;
    step();
    chk_out("rc7", 0, 1, 3);
    for (int k = 4; k <= 6; k++) begin
      step();
      chk_out($sformatf("r1.%0d", k), 1, 0, k);
    end

    // Underflow at rate 3 after four primed symbols
    do_reset();
    preload(4);
    start_run(4'd3);
    chk_out("u1", 1, 0, 1);
    for (int k = 2; k <= 4; k++) begin
      repeat (3) step();
      chk_out($sformatf("u%0d", k), 1, 0, k);
    end
    repeat (3) step();
    chk_out("u5", 1, 0, 0);
    chk("u5 uflow", int'(underflow), 1);
    chk("u5 active", int'(active), 1);
    step();
    chk("u5 pulse end", int'(underflow), 0);
    chk("u5 sym hold", int'(sym_data), 0);
`ifdef UPSCHED_UFLOW_CNT_EN
    chk("uflow_cnt", int'(uflow_cnt), 1);
`endif

    // Drop enable mid-period, then resume
    do_reset();
    preload(8);
    start_run(4'd4);
    step();
    chk_out("st1", 0, 1, 1);
    enable = 1'b0;
    step();
    chk_out("st2", 0, 2, 1);
    chk("st2 active", int'(active), 1);
    step();
    chk_out("st3", 0, 3, 1);
    step();
    chk_out("idle", 0, 0, 0);
    chk("idle active", int'(active), 0);
    chk("idle level", int'(fifo_level), 7);
    start_run(4'd4);
    chk_out("resume", 1, 0, 2);
    chk("resume active", int'(active), 1);

    // Async reset mid-period
    do_reset();
    preload(8);
    start_run(4'd4);
    step();
    step();
    chk("pre-rst phase", int'(phase), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst sym", int'(sym_data), 0);
    chk("arst phase", int'(phase), 0);
    chk("arst active", int'(active), 0);
    chk("arst level", int'(fifo_level), 0);
    chk("arst strobe", int'(sym_strobe), 0);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    step();
    chk("post-rst ready", int'(s_ready), 1);
    chk("post-rst active", int'(active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/upsample_scheduler.md
Name: upsample_scheduler

Overview:
Symbol-rate scheduler placed between the QAM symbol mapper and the upsampler in the DSP stack. Buffers 4-bit symbols from the mapper through a valid/ready handshake and releases exactly one symbol per upsampling period. Owns the sample-phase counter, applies rate changes only at period boundaries, and flags underflow. Downstream stages use sym_strobe and phase to align with symbol boundaries.

Parameters:
DATA_W, 4, symbol width
RATE_W, 4, width of rate config and phase counter
FIFO_DEPTH, 8, symbol buffer entries (power of 2)
PRIME_LVL, 4, FIFO level required before streaming starts (1..FIFO_DEPTH)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset; clears all state including FIFO
enable  in  1  streaming request from top-level control
rate_cfg  in  RATE_W  samples per symbol; 0 treated as 1
s_data  in  DATA_W  symbol from mapper
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; combinational, equals (level != FIFO_DEPTH)
sym_data  out  DATA_W  current symbol, held for the whole period
sym_strobe  out  1  high on phase 0 of each period in RUN/STOP
phase  out  RATE_W  sample index within period, 0..rate_q-1
active  out  1  high in RUN and STOP
underflow  out  1  one-cycle pulse: period started with FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values: sym_data=0, sym_strobe=0, phase=0, active=0, underflow=0, fifo_level=0, state=IDLE, rate_q=1. s_ready=1 once rst releases.
- Push when s_valid && s_ready. Push while full is impossible (s_ready=0). Push and pop in the same cycle leaves the level unchanged. No bypass path: pushing into an empty FIFO during a period-start cycle still produces underflow.
- rate_q is the registered effective rate, with rate_cfg==0 mapped to 1.
  - Loaded in IDLE and PRIME every cycle.
  - In RUN, loaded only on the last sample (phase==rate_q-1). The new rate takes effect from the next period.
  - A mid-period change never truncates or extends the current period.
- FSM:
  - IDLE: phase=0, no pops. enable=1 -> PRIME.
  - PRIME: enable=0 -> IDLE. fifo_level>=PRIME_LVL -> RUN.
  - RUN: the cycle after entry is phase 0 of the first period. enable=0 -> STOP.
  - STOP: finish the current period. At phase==rate_q-1 -> IDLE. FIFO contents are retained. enable reasserted in STOP -> RUN with no gap.
- Period start (phase 0 in RUN/STOP), registered outputs:
  - sym_strobe=1, phase=0.
  - If FIFO is non-empty: pop, and sym_data=head.
  - If FIFO is empty: sym_data=0, underflow=1 for that cycle, state stays RUN.
- Within a period, phase increments by 1 and wraps to 0 after rate_q-1. With rate_q=1, sym_strobe stays high every cycle and one symbol is popped per cycle.
- sym_data holds its value between strobes. It returns to 0 on entering IDLE.
- An asynchronous reset mid-stream discards buffered symbols and the partial period immediately.

Optional Feature:
UPSCHED_UFLOW_CNT_EN
- Defined: adds output uflow_cnt[15:0], a saturating count of underflow pulses (holds at 16'hFFFF). Cleared by rst and on each IDLE->PRIME transition.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (upsched_pkg) holds:
  - the FSM state typedef (IDLE, PRIME, RUN, STOP)
  - default DATA_W/RATE_W constants
  - the rate-clamp function (0 -> 1)
- One natural sub-module: upsched_fifo. Synchronous FIFO with push/pop/level/full/empty, same clk and rst, parameterised by DATA_W and FIFO_DEPTH.

Test Plan:
- Reset then enable=1, rate_cfg=4, push symbols 1..8 back-to-back:
  - RUN is entered once level hits 4.
  - sym_strobe occurs every 4 cycles.
  - sym_data sequence is 1,2,...,8; phase cycles 0,1,2,3.
- Fill 8 symbols with no pops, hold s_valid=1 -> s_ready=0 and fifo_level=8. The extra symbol is not accepted; after one pop it is accepted and the level returns to 8.
- rate=4 RUN, change rate_cfg to 2 at phase 1:
  - The current period completes at 4 cycles.
  - Following periods are 2 cycles.
  - rate_cfg=0 yields a strobe every cycle.
- Prime 4 symbols at rate=3 with no further pushes:
  - Four symbols are output.
  - The 5th period start gives sym_data=0 and a one-cycle underflow pulse.
  - uflow_cnt=1 when UPSCHED_UFLOW_CNT_EN is defined.
- Drop enable at phase 1 of rate=4:
  - Phases 2 and 3 complete, then IDLE with active=0 and sym_data=0.
  - Remaining FIFO symbols are retained, and re-enable resumes from them.
- Assert rst low at phase 2 mid-stream -> all outputs and fifo_level are 0 immediately, asynchronously. After release, s_ready=1 and state is IDLE.
